ram_loader: RTL and testbench

- Upstream feeder for the Hack data/instruction RAM.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit words, high byte first.
- Drives the RAM's address/dataIn/load port to write a contiguous image starting at address 0.
- Used at boot to load program or data images from a serial front end before the CPU is released.

---
 rtl/ram_loader.sv | 165 ++++++++++++++++
 tb/tb_ram_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Boot loader: LEN-prefixed big-endian byte stream -> 16-bit RAM writes from address 0, one word per 3 cycles at best.
// Define RAM_LOADER_CHECKSUM_EN to require a trailing 16-bit SUM word; otherwise no sum logic is built.
module ram_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 13,
   parameter int MEM_DEPTH  = 8192
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [7:0]            byteIn,
   input  logic                  byteValid,
   output logic                  byteReady,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  load,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   wordCount
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO,
      S_WRITE, S_SUM_HI, S_SUM_LO, S_DONE, S_ERROR
   } state_t;

`ifdef RAM_LOADER_CHECKSUM_EN
   localparam state_t S_FIN = S_SUM_HI;
`else
   localparam state_t S_FIN = S_DONE;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
   logic [15:0]           len_q, len_d;
`ifdef RAM_LOADER_CHECKSUM_EN
   logic [15:0]           sum_q, sum_d;
   logic [7:0]            sum_hi_q, sum_hi_d;
`endif

   logic        byte_acc;
   logic        restart;
   logic        last_word;
   logic [15:0] len_word;

   assign byte_acc  = byteValid && byteReady;
   assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign len_word  = {len_q[15:8], byteIn};
   assign last_word = (32'(wcount_q) + 32'd1) == 32'(len_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
         S_LEN_HI: if (byte_acc) state_d = S_LEN_LO;
         S_LEN_LO: begin
            if (byte_acc) begin
               if (len_word == 16'd0)
                  state_d = S_FIN;
               else if ({16'd0, len_word} > 32'(MEM_DEPTH))
                  state_d = S_ERROR;
               else
                  state_d = S_DAT_HI;
            end
         end
         S_DAT_HI: if (byte_acc) state_d = S_DAT_LO;
         S_DAT_LO: if (byte_acc) state_d = S_WRITE;
         S_WRITE:  state_d = last_word ? S_FIN : S_DAT_HI;
`ifdef RAM_LOADER_CHECKSUM_EN
         S_SUM_HI: if (byte_acc) state_d = S_SUM_LO;
         S_SUM_LO: if (byte_acc) state_d = ({sum_hi_q, byteIn} == sum_q) ? S_DONE : S_ERROR;
`endif
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byteReady = 1'b0;
      load      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      case (state_q)
         S_IDLE:  busy = 1'b0;
         S_DONE:  begin busy = 1'b0; done  = 1'b1; end
         S_ERROR: begin busy = 1'b0; error = 1'b1; end
         S_WRITE: load = 1'b1;
         default: byteReady = 1'b1;
      endcase
   end

   // Datapath: capture bytes into the field they belong to; WRITE bumps the pointers.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wcount_d = wcount_q;
      len_d    = len_q;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
      sum_hi_d = sum_hi_q;
`endif
      if (restart) begin
         addr_d   = '0;
         wcount_d = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
         sum_d    = '0;
`endif
      end
      case (state_q)
         S_LEN_HI: if (byte_acc) len_d[15:8]  = byteIn;
         S_LEN_LO: if (byte_acc) len_d[7:0]   = byteIn;
         S_DAT_HI: if (byte_acc) data_d[15:8] = byteIn;
         S_DAT_LO: if (byte_acc) data_d[7:0]  = byteIn;
         S_WRITE: begin
            addr_d   = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            wcount_d = wcount_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_d    = sum_q + data_q;
`endif
         end
`ifdef RAM_LOADER_CHECKSUM_EN
         S_SUM_HI: if (byte_acc) sum_hi_d = byteIn;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q   <= '0;
         data_q   <= '0;
         wcount_q <= '0;
         len_q    <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
         sum_q    <= '0;
         sum_hi_q <= '0;
`endif
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         wcount_q <= wcount_d;
         len_q    <= len_d;
`ifdef RAM_LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
         sum_hi_q <= sum_hi_d;
`endif
      end
   end

   assign address   = addr_q;
   assign dataOut   = data_q;
   assign wordCount = wcount_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: expected RAM writes are queued at stimulus time and popped by a load monitor.
module tb_ram_loader;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        byteReady;
   logic [12:0] address;
   logic [15:0] dataOut;
   logic        load;
   logic        busy;
   logic        done;
   logic        error;
   logic [13:0] wordCount;

   ram_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .MEM_DEPTH(8192)) dut (
      .CLK(CLK), .RST(RST), .start(start), .byteIn(byteIn), .byteValid(byteValid),
      .byteReady(byteReady), .address(address), .dataOut(dataOut), .load(load),
      .busy(busy), .done(done), .error(error), .wordCount(wordCount)
   );

   always #5 CLK = ~CLK;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  bytes[$];
   logic [28:0] exp_q[$];
   logic [28:0] mon_e;
   logic [15:0] model_sum;
   logic [15:0] tbram [0:8191];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(posedge CLK) if (load) tbram[address] <= dataOut;

   // Scoreboard monitor: every load cycle must match the next queued write.
   always @(negedge CLK) begin
      if (load === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_load", 32'(address), 32'h1_0000);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(address), 32'(mon_e[28:16]));
            check("wr_data", 32'(dataOut), 32'(mon_e[15:0]));
         end
      end
   end

   task automatic add_word(input logic [15:0] w);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
   endtask

   task automatic new_stream(input logic [15:0] n);
      bytes.delete();
      model_sum = 16'h0;
      add_word(n);
   endtask

   task automatic add_data(input logic [12:0] a, input logic [15:0] w);
      add_word(w);
      exp_q.push_back({a, w});
      model_sum = model_sum + w;
   endtask

   task automatic finish_stream();
`ifdef RAM_LOADER_CHECKSUM_EN
      add_word(model_sum);
`endif
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic send_bytes(input int gap, input int start_at, input int limit);
      bit acc;
      int cyc;
      for (int i = 0; i < bytes.size() && i < limit; i++) begin
         if (gap > 0 && (i % 2) == 1) begin
            byteValid = 1'b0;
            repeat (gap) begin
               @(posedge CLK); #1;
            end
         end
         if (i == start_at) start = 1'b1;
         byteIn    = bytes[i];
         byteValid = 1'b1;
         acc = 1'b0;
         cyc = 0;
         while (!acc && cyc < 50) begin
            @(negedge CLK);
            acc = byteReady;
            @(posedge CLK); #1;
            start = 1'b0;
            cyc++;
         end
         if (!acc) begin
            check("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
            break;
         end
      end
      byteValid = 1'b0;
      byteIn    = 8'h00;
   endtask

   task automatic wait_idle();
      int cyc = 0;
      @(negedge CLK);
      while (busy && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'h0);
   endtask

   task automatic check_end(input string tag, input logic d, input logic e, input int wc, input int ad);
      check({tag, "_done"}, 32'(done), 32'(d));
      check({tag, "_error"}, 32'(error), 32'(e));
      check({tag, "_wordCount"}, 32'(wordCount), 32'(wc));
      check({tag, "_address"}, 32'(address), 32'(ad));
      check({tag, "_byteReady"}, 32'(byteReady), 32'h0);
      check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; start = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
      @(negedge CLK);
      check("rst_address", 32'(address), 32'h0);
      check("rst_dataOut", 32'(dataOut), 32'h0);
      check("rst_load", 32'(load), 32'h0);
      check("rst_byteReady", 32'(byteReady), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      check("rst_wordCount", 32'(wordCount), 32'h0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Basic 3-word image, byteValid always high
      new_stream(16'd3);
      add_data(13'd0, 16'h1234); add_data(13'd1, 16'hABCD); add_data(13'd2, 16'h0001);
      finish_stream();
      pulse_start();
      check("busy_after_start", 32'(busy), 32'h1);
      send_bytes(0, -1, 1000);
      wait_idle();
      check_end("basic", 1'b1, 1'b0, 3, 3);

      // Same image with 5-cycle stalls before each low byte
      new_stream(16'd3);
      add_data(13'd0, 16'h1234); add_data(13'd1, 16'hABCD); add_data(13'd2, 16'h0001);
      finish_stream();
      pulse_start();
      send_bytes(5, -1, 1000);
      wait_idle();
      check_end("stall", 1'b1, 1'b0, 3, 3);

      // Oversized length rejected after the second byte, then empty image
      new_stream(16'h2001);
      pulse_start();
      send_bytes(0, -1, 1000);
      wait_idle();
      check_end("oversize", 1'b0, 1'b1, 0, 0);
      new_stream(16'd0);
      finish_stream();
      pulse_start();
      send_bytes(0, -1, 1000);
      wait_idle();
      check_end("empty", 1'b1, 1'b0, 0, 0);

      // Start pulse in the middle of the data is ignored
      new_stream(16'd3);
      add_data(13'd0, 16'hCAFE); add_data(13'd1, 16'h0102); add_data(13'd2, 16'hFFFF);
      finish_stream();
      pulse_start();
      send_bytes(0, 3, 1000);
      wait_idle();
      check_end("midstart", 1'b1, 1'b0, 3, 3);

      // Reset after word 2's high byte: RAM[0] written, RAM[1] keeps 0x0102
      new_stream(16'd3);
      add_data(13'd0, 16'h1111); add_word(16'h2222); add_word(16'h3333);
      pulse_start();
      send_bytes(0, -1, 5);
      #2;
      RST = 1'b1;
      #1;
      check("arst_load", 32'(load), 32'h0);
      check("arst_byteReady", 32'(byteReady), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check_end("arst", 1'b0, 1'b0, 0, 0);
      check("arst_busy_after", 32'(busy), 32'h0);
      check("arst_ram0", 32'(tbram[0]), 32'h1111);
      check("arst_ram1", 32'(tbram[1]), 32'h0102);

`ifdef RAM_LOADER_CHECKSUM_EN
      new_stream(16'd2);
      add_data(13'd0, 16'h1234); add_data(13'd1, 16'hABCD);
      add_word(16'hBE01);
      pulse_start();
      send_bytes(0, -1, 1000);
      wait_idle();
      check_end("sum_ok", 1'b1, 1'b0, 2, 2);
      new_stream(16'd2);
      add_data(13'd0, 16'h1234); add_data(13'd1, 16'hABCD);
      add_word(16'hBE02);
      pulse_start();
      send_bytes(0, -1, 1000);
      wait_idle();
      check_end("sum_bad", 1'b0, 1'b1, 2, 2);
      check("sum_bad_ram0", 32'(tbram[0]), 32'h1234);
      check("sum_bad_ram1", 32'(tbram[1]), 32'hABCD);
`endif

      repeat (3) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
